uart_tx_ctrl: RTL and testbench

Frame controller for the UART transmitter. It accepts a parallel byte from the bus-side producer and sequences the line through start, data, optional parity and stop bits. It drives the downstream bit serializer: held data, a start pulse and the serializer enable. It muxes start, data, parity and stop bits onto the TX pin. One `clk` cycle equals one bit time; baud generation lives upstream.

---
 rtl/uart_tx_ctrl.sv | 80 ++++++++
 tb/tb_uart_tx_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, data, optional parity and stop
// bits onto TX_OUT, driving an external bit serializer. One clk cycle is one bit time.
module uart_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_Valid,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             ser_data,
    input  logic             ser_done,
    output logic [WIDTH-1:0] ser_p_data,
    output logic             ser_start,
    output logic             ser_en,
    output logic             TX_OUT,
    output logic             Busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data_reg;
    logic             par_bit;
    logic             par_en_reg;
    logic             accept;

    function automatic logic frame_parity(input logic [WIDTH-1:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

    // A new frame is taken only from IDLE or during the stop bit (back-to-back)
    assign accept = Data_Valid && ((state == IDLE) || (state == STOP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            data_reg   <= '0;
            par_bit    <= 1'b0;
            par_en_reg <= 1'b0;
        end else begin
            if (accept) begin
                data_reg   <= P_DATA;
                par_en_reg <= PAR_EN;
                par_bit    <= frame_parity(P_DATA, PAR_TYP);
            end
            case (state)
                IDLE:    if (Data_Valid) state <= START;
                START:   state <= DATA;
                DATA:    if (ser_done) state <= par_en_reg ? PARITY : STOP;
                PARITY:  state <= STOP;
                STOP:    state <= Data_Valid ? START : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ser_p_data = data_reg;
    assign ser_start  = (state == START);
    assign ser_en     = (state == DATA);
    assign Busy       = (state != IDLE);

    always_comb begin
        TX_OUT = 1'b1;
        case (state)
            START:   TX_OUT = 1'b0;
            DATA:    TX_OUT = ser_data;
            PARITY:  TX_OUT = par_bit;
            default: TX_OUT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: behavioural frame model compared every cycle, directed
// frames pinned to hand-derived line patterns, then randomized traffic with resets.
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] P_DATA = '0;
    logic         Data_Valid = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         ser_data;
    logic         ser_done;
    logic [W-1:0] ser_p_data;
    logic         ser_start;
    logic         ser_en;
    logic         TX_OUT;
    logic         Busy;

    int total = 0;
    int bad   = 0;

    uart_tx_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_p_data (ser_p_data),
        .ser_start  (ser_start),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    // Compliant serializer, plus junk on its outputs whenever it is not enabled
    logic [3:0] cnt = '0;
    logic       junk_data = 1'b0;
    logic       junk_done = 1'b0;

    always @(posedge clk) begin
        if (ser_start) cnt <= '0;
        else if (ser_en && cnt != 4'd15) cnt <= cnt + 4'd1;
    end

    assign ser_data = ser_en ? ((cnt < 4'(W)) ? ser_p_data[cnt[2:0]] : 1'b0) : junk_data;
    assign ser_done = ser_en ? (cnt == 4'(W - 1)) : junk_done;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            junk_data = 1'($urandom_range(0, 1));
            junk_done = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one expected entry per bit time of every accepted frame
    typedef struct {
        logic         tx;
        logic         busy;
        logic         en;
        logic         st;
        logic         stop;
        logic [W-1:0] pd;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] lat = '0;

    task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        exp_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < W; i++) ones += int'(d[i]);
        lat = d;
        e = '{tx: 1'b0, busy: 1'b1, en: 1'b0, st: 1'b1, stop: 1'b0, pd: d};
        q.push_back(e);
        for (int i = 0; i < W; i++) begin
            e = '{tx: d[i], busy: 1'b1, en: 1'b1, st: 1'b0, stop: 1'b0, pd: d};
            q.push_back(e);
        end
        if (pe) begin
            e = '{tx: 1'((ones % 2) != 0) ^ pt, busy: 1'b1, en: 1'b0, st: 1'b0, stop: 1'b0, pd: d};
            q.push_back(e);
        end
        e = '{tx: 1'b1, busy: 1'b1, en: 1'b0, st: 1'b0, stop: 1'b1, pd: d};
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        logic can_acc;
        if (!rst) begin
            q.delete();
            lat = '0;
        end else begin
            can_acc = (q.size() == 0) || q[0].stop;
            if (q.size() != 0) void'(q.pop_front());
            if (Data_Valid && can_acc) push_frame(P_DATA, PAR_EN, PAR_TYP);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) e = q[0];
        else e = '{tx: 1'b1, busy: 1'b0, en: 1'b0, st: 1'b0, stop: 1'b0, pd: lat};
        chk("model TX_OUT", 32'(TX_OUT), 32'(e.tx));
        chk("model Busy", 32'(Busy), 32'(e.busy));
        chk("model ser_en", 32'(ser_en), 32'(e.en));
        chk("model ser_start", 32'(ser_start), 32'(e.st));
        chk("model ser_p_data", 32'(ser_p_data), 32'(e.pd));
    end

    // mode 0 plain, 1 flip sampled inputs mid-frame, 2 back-to-back with d2, 3 request during DATA
    task automatic directed(input string name, input logic [W-1:0] d, input logic pe,
                            input logic pt, input int mode, input logic [W-1:0] d2,
                            input int n, input logic [31:0] exp_tx, input logic [31:0] exp_busy,
                            input int exp_starts, input int exp_ens);
        logic [31:0] tx_v;
        logic [31:0] busy_v;
        int          starts;
        int          ens;
        tx_v = '0;
        busy_v = '0;
        starts = 0;
        ens = 0;
        @(negedge clk);
        #2;
        P_DATA = d;
        PAR_EN = pe;
        PAR_TYP = pt;
        Data_Valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_v[i] = TX_OUT;
            busy_v[i] = Busy;
            starts += int'(ser_start);
            ens += int'(ser_en);
            if (i == 0) chk({name, " p_data"}, 32'(ser_p_data), 32'(d));
            if (mode == 2 && i == 10) chk({name, " p_data2"}, 32'(ser_p_data), 32'(d2));
            #2;
            Data_Valid = 1'b0;
            if (mode == 1 && i == 3) begin
                PAR_TYP = ~PAR_TYP;
                PAR_EN = ~PAR_EN;
                P_DATA = ~P_DATA;
            end
            if (mode == 2 && i == 9) begin
                Data_Valid = 1'b1;
                P_DATA = d2;
            end
            if (mode == 3 && i == 3) begin
                Data_Valid = 1'b1;
                P_DATA = 8'hFF;
            end
        end
        chk({name, " tx"}, tx_v, exp_tx);
        chk({name, " busy"}, busy_v, exp_busy);
        chk({name, " starts"}, 32'(starts), 32'(exp_starts));
        chk({name, " ens"}, 32'(ens), 32'(exp_ens));
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, " TX_OUT"}, 32'(TX_OUT), 32'd1);
        chk({name, " Busy"}, 32'(Busy), 32'd0);
        chk({name, " ser_en"}, 32'(ser_en), 32'd0);
        chk({name, " ser_start"}, 32'(ser_start), 32'd0);
        chk({name, " ser_p_data"}, 32'(ser_p_data), 32'd0);
    endtask

    initial begin
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        directed("a5_nopar", 8'hA5, 1'b0, 1'b0, 0, 8'h00, 11,
                 32'b11101001010, 32'b01111111111, 1, W);
        directed("07_even", 8'h07, 1'b1, 1'b0, 0, 8'h00, 12,
                 32'b111000001110, 32'b011111111111, 1, W);
        directed("07_odd_flip", 8'h07, 1'b1, 1'b1, 1, 8'h00, 12,
                 32'b110000001110, 32'b011111111111, 1, W);
        directed("b2b", 8'h55, 1'b0, 1'b0, 2, 8'h0F, 21,
                 32'b110000111101010101010, 32'b011111111111111111111, 2, 2 * W);
        directed("reject", 8'h12, 1'b0, 1'b0, 3, 8'h00, 12,
                 32'b111000100100, 32'b001111111111, 1, W);

        // Reset asserted in the 4th data cycle of a frame
        @(negedge clk);
        #2;
        P_DATA = 8'h3C;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        Data_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            Data_Valid = 1'b0;
        end
        rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        directed("3c_after_reset", 8'h3C, 1'b0, 1'b0, 0, 8'h00, 11,
                 32'b11001111000, 32'b01111111111, 1, W);

        // Randomized traffic with occasional asynchronous resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            #2;
            rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            Data_Valid = ($urandom_range(0, 3) == 0);
            P_DATA = W'($urandom);
            PAR_EN = 1'($urandom_range(0, 1));
            PAR_TYP = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        Data_Valid = 1'b0;
        repeat (14) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
